riscv_checkpoint_monitor: RTL and testbench

- Synthesizable, parametrised run-time checker for the RISC-V core.
- Watches NUM_INST, OUTPUT_PORT and HALT, and compares OUTPUT_PORT against a programmable in-order table of (instruction count, expected value) checkpoints.
- Unlike a fixed bench table, it counts passes, fails and missed checkpoints; it can continue after a failure, has a stall watchdog, and reports a final verdict.
- Sits beside RISCV_TOP in benches and FPGA builds.

---
 rtl/riscv_checkpoint_monitor_if.sv | 69 ++++++
 rtl/riscv_checkpoint_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_riscv_checkpoint_monitor.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_checkpoint_monitor_if.sv
// riscv_checkpoint_monitor_if
//   Bundles the configuration, core-observation and result signals of the
//   checkpoint monitor.
//   master : drives the table/config strobes and the observed core signals
//            (bench or SoC glue).
//   slave  : the monitor itself.
//   Optional: CFG_MASK exists only when CHK_MASK_EN is defined.
//   Signal summary:
//     CFG_WE, CFG_ADDR, CFG_INST, CFG_ANS  table write port
//     CFG_MASK                             per-entry compare mask (CHK_MASK_EN)
//     NUM_ENTRIES, START                   run setup
//     NUM_INST, OUTPUT_PORT, HALT          observed core signals
//     CHK_EVENT, CHK_IDX, CHK_OK, CHK_MISS per-checkpoint result pulse
//     PASS_CNT, FAIL_CNT, FIRST_FAIL_*,    running statistics
//     CYCLE_CNT
//     DONE, PASS, TIMEOUT, INCOMPLETE      final status
interface riscv_checkpoint_monitor_if #(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 5
);
  logic              CFG_WE;
  logic [IWIDTH-1:0] CFG_ADDR;
  logic [DWIDTH-1:0] CFG_INST;
  logic [DWIDTH-1:0] CFG_ANS;
`ifdef CHK_MASK_EN
  logic [DWIDTH-1:0] CFG_MASK;
`endif
  logic [IWIDTH:0]   NUM_ENTRIES;
  logic              START;
  logic [DWIDTH-1:0] NUM_INST;
  logic [DWIDTH-1:0] OUTPUT_PORT;
  logic              HALT;

  logic              CHK_EVENT;
  logic [IWIDTH-1:0] CHK_IDX;
  logic              CHK_OK;
  logic              CHK_MISS;
  logic [IWIDTH:0]   PASS_CNT;
  logic [IWIDTH:0]   FAIL_CNT;
  logic [IWIDTH-1:0] FIRST_FAIL_IDX;
  logic [DWIDTH-1:0] FIRST_FAIL_VAL;
  logic [31:0]       CYCLE_CNT;
  logic              DONE;
  logic              PASS;
  logic              TIMEOUT;
  logic              INCOMPLETE;

  modport master (
`ifdef CHK_MASK_EN
    output CFG_MASK,
`endif
    output CFG_WE, CFG_ADDR, CFG_INST, CFG_ANS, NUM_ENTRIES, START,
    output NUM_INST, OUTPUT_PORT, HALT,
    input  CHK_EVENT, CHK_IDX, CHK_OK, CHK_MISS, PASS_CNT, FAIL_CNT,
    input  FIRST_FAIL_IDX, FIRST_FAIL_VAL, CYCLE_CNT, DONE, PASS, TIMEOUT,
    input  INCOMPLETE
  );

  modport slave (
`ifdef CHK_MASK_EN
    input  CFG_MASK,
`endif
    input  CFG_WE, CFG_ADDR, CFG_INST, CFG_ANS, NUM_ENTRIES, START,
    input  NUM_INST, OUTPUT_PORT, HALT,
    output CHK_EVENT, CHK_IDX, CHK_OK, CHK_MISS, PASS_CNT, FAIL_CNT,
    output FIRST_FAIL_IDX, FIRST_FAIL_VAL, CYCLE_CNT, DONE, PASS, TIMEOUT,
    output INCOMPLETE
  );
endinterface

// File: rtl/riscv_checkpoint_monitor.sv
// riscv_checkpoint_monitor
//   Run-time checker for the RISC-V core. Compares OUTPUT_PORT against an
//   in-order table of (instruction count, expected value) checkpoints while
//   the core runs, counts passes / fails / misses, runs a stall watchdog and
//   reports a final verdict.
//   Ports:
//     CLK   clock
//     RSTn  asynchronous active-low reset (table contents are not reset)
//     bus   riscv_checkpoint_monitor_if.slave (config, core observation,
//           results and status)
//   Optional feature: define CHK_MASK_EN to add a per-entry compare mask
//   (CFG_MASK); the compare becomes ((OUTPUT_PORT ^ ANS) & MASK) == 0.
//
//   state  | meaning
//   S_IDLE | table writable, waiting for START
//   S_RUN  | checking checkpoints, watchdog and cycle counter active
//   S_DONE | verdict held; START begins a new run with the same table
module riscv_checkpoint_monitor #(
  parameter int NUM_TEST     = 32,
  parameter int DWIDTH       = 32,
  parameter int IWIDTH       = 5,
  parameter int STOP_ON_FAIL = 1,
  parameter int TIMEOUT_CYC  = 4096
) (
  input logic                        CLK,
  input logic                        RSTn,
  riscv_checkpoint_monitor_if.slave  bus
);

  localparam logic [IWIDTH:0] NT      = (IWIDTH+1)'(NUM_TEST);
  localparam bit              WD_ON   = (TIMEOUT_CYC != 0);
  localparam logic [31:0]     WD_LOAD = WD_ON ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [DWIDTH-1:0] tab_inst [NUM_TEST];
  logic [DWIDTH-1:0] tab_ans  [NUM_TEST];
`ifdef CHK_MASK_EN
  logic [DWIDTH-1:0] tab_mask [NUM_TEST];
`endif

  logic [IWIDTH:0]   ptr;
  logic [IWIDTH:0]   num_ent;
  logic [DWIDTH-1:0] last_inst;
  logic [31:0]       wd_cnt;

  logic              chk_event;
  logic [IWIDTH-1:0] chk_idx;
  logic              chk_ok;
  logic              chk_miss;
  logic [IWIDTH:0]   pass_cnt;
  logic [IWIDTH:0]   fail_cnt;
  logic [IWIDTH-1:0] first_fail_idx;
  logic [DWIDTH-1:0] first_fail_val;
  logic [31:0]       cycle_cnt;
  logic              done;
  logic              pass;
  logic              timeout;
  logic              incomplete;

  // Table storage: plain RAM, no reset, writable only while idle.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && bus.CFG_WE && ({1'b0, bus.CFG_ADDR} < NT)) begin
      tab_inst[bus.CFG_ADDR] <= bus.CFG_INST;
      tab_ans[bus.CFG_ADDR]  <= bus.CFG_ANS;
`ifdef CHK_MASK_EN
      tab_mask[bus.CFG_ADDR] <= bus.CFG_MASK;
`endif
    end
  end

  logic [IWIDTH-1:0] idx;
  logic              active, match, hit, miss, ok, bad, resolve;
  logic              stalled, wd_expire, incomplete_nxt;
  logic [IWIDTH:0]   ptr_nxt, fail_nxt;

  always_comb begin
    idx    = ptr[IWIDTH-1:0];
    // ptr < num_ent <= NUM_TEST keeps the table read in range whenever used.
    active = (ptr < num_ent);
`ifdef CHK_MASK_EN
    match  = (((bus.OUTPUT_PORT ^ tab_ans[idx]) & tab_mask[idx]) == '0);
`else
    match  = (bus.OUTPUT_PORT == tab_ans[idx]);
`endif
    hit            = active && (bus.NUM_INST == tab_inst[idx]);
    miss           = active && (bus.NUM_INST > tab_inst[idx]);
    ok             = hit && match;
    bad            = (hit && !match) || miss;
    resolve        = hit || miss;
    ptr_nxt        = ptr + (IWIDTH+1)'(resolve);
    fail_nxt       = fail_cnt + (IWIDTH+1)'(bad);
    incomplete_nxt = (ptr_nxt < num_ent);
    stalled        = (bus.NUM_INST == last_inst);
    // Down-counter reloaded on every NUM_INST change; expiry is the stalled
    // cycle on which it has already reached zero (TIMEOUT_CYC-th stall).
    wd_expire      = WD_ON && stalled && (wd_cnt == 32'd0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= S_IDLE;
      ptr            <= '0;
      num_ent        <= '0;
      last_inst      <= '0;
      wd_cnt         <= '0;
      chk_event      <= 1'b0;
      chk_idx        <= '0;
      chk_ok         <= 1'b0;
      chk_miss       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
      cycle_cnt      <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      incomplete     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          chk_event <= 1'b0;
          if (bus.START) begin
            state          <= S_RUN;
            ptr            <= '0;
            num_ent        <= (bus.NUM_ENTRIES > NT) ? NT : bus.NUM_ENTRIES;
            last_inst      <= bus.NUM_INST;
            wd_cnt         <= WD_LOAD;
            chk_idx        <= '0;
            chk_ok         <= 1'b0;
            chk_miss       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            cycle_cnt      <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            incomplete     <= 1'b0;
          end
        end

        S_RUN: begin
          chk_event <= resolve;
          if (resolve) begin
            chk_idx  <= idx;
            chk_ok   <= ok;
            chk_miss <= miss;
            ptr      <= ptr_nxt;
            pass_cnt <= pass_cnt + (IWIDTH+1)'(ok);
            fail_cnt <= fail_nxt;
            // fail_cnt==0 means nothing has been latched yet this run.
            if (bad && fail_cnt == '0) begin
              first_fail_idx <= idx;
              first_fail_val <= miss ? '0 : bus.OUTPUT_PORT;
            end
          end

          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;

          last_inst <= bus.NUM_INST;
          if (!stalled)            wd_cnt <= WD_LOAD;
          else if (wd_cnt != '0)   wd_cnt <= wd_cnt - 32'd1;

          if (bus.HALT) begin
            state      <= S_DONE;
            done       <= 1'b1;
            incomplete <= incomplete_nxt;
            pass       <= (fail_nxt == '0) && !incomplete_nxt;
          end else if (bad && STOP_ON_FAIL != 0) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (wd_expire) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.CHK_EVENT      = chk_event;
  assign bus.CHK_IDX        = chk_idx;
  assign bus.CHK_OK         = chk_ok;
  assign bus.CHK_MISS       = chk_miss;
  assign bus.PASS_CNT       = pass_cnt;
  assign bus.FAIL_CNT       = fail_cnt;
  assign bus.FIRST_FAIL_IDX = first_fail_idx;
  assign bus.FIRST_FAIL_VAL = first_fail_val;
  assign bus.CYCLE_CNT      = cycle_cnt;
  assign bus.DONE           = done;
  assign bus.PASS           = pass;
  assign bus.TIMEOUT        = timeout;
  assign bus.INCOMPLETE     = incomplete;

endmodule

// File: tb/tb_riscv_checkpoint_monitor.sv
// tb_riscv_checkpoint_monitor
//   Directed bench for riscv_checkpoint_monitor. Two instances share one
//   stimulus: dut_a stops on the first fail and has a 16-cycle watchdog,
//   dut_b keeps checking and has the watchdog disabled.
module tb_riscv_checkpoint_monitor;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_inst = '0;
  logic [DW-1:0] cfg_ans = '0;
  logic [DW-1:0] cfg_mask = '1;
  logic [IW:0]   num_entries = '0;
  logic          start = 1'b0;
  logic [DW-1:0] num_inst = '0;
  logic [DW-1:0] output_port = '0;
  logic          halt = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_checkpoint_monitor_if #(.DWIDTH(DW), .IWIDTH(IW)) ifa ();
  riscv_checkpoint_monitor_if #(.DWIDTH(DW), .IWIDTH(IW)) ifb ();

  assign ifa.CFG_WE = cfg_we;           assign ifb.CFG_WE = cfg_we;
  assign ifa.CFG_ADDR = cfg_addr;       assign ifb.CFG_ADDR = cfg_addr;
  assign ifa.CFG_INST = cfg_inst;       assign ifb.CFG_INST = cfg_inst;
  assign ifa.CFG_ANS = cfg_ans;         assign ifb.CFG_ANS = cfg_ans;
`ifdef CHK_MASK_EN
  assign ifa.CFG_MASK = cfg_mask;       assign ifb.CFG_MASK = cfg_mask;
`endif
  assign ifa.NUM_ENTRIES = num_entries; assign ifb.NUM_ENTRIES = num_entries;
  assign ifa.START = start;             assign ifb.START = start;
  assign ifa.NUM_INST = num_inst;       assign ifb.NUM_INST = num_inst;
  assign ifa.OUTPUT_PORT = output_port; assign ifb.OUTPUT_PORT = output_port;
  assign ifa.HALT = halt;               assign ifb.HALT = halt;

  riscv_checkpoint_monitor #(.NUM_TEST(NT), .DWIDTH(DW), .IWIDTH(IW),
    .STOP_ON_FAIL(1), .TIMEOUT_CYC(16)) dut_a (.CLK(clk), .RSTn(rst_n), .bus(ifa));
  riscv_checkpoint_monitor #(.NUM_TEST(NT), .DWIDTH(DW), .IWIDTH(IW),
    .STOP_ON_FAIL(0), .TIMEOUT_CYC(0)) dut_b (.CLK(clk), .RSTn(rst_n), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int inst, input logic [31:0] ans);
    cfg_we = 1'b1; cfg_addr = IW'(addr); cfg_inst = DW'(inst); cfg_ans = ans;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go(input int entries);
    num_entries = (IW+1)'(entries); num_inst = '0; output_port = '0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] good_ans(input int n);
    case (n)
      4:       return 32'h0eec;
      6:       return 32'h0000;
      8:       return 32'h0001;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    // reset
    #12;
    check("rst_done", ifa.DONE, 0);
    check("rst_pass", ifa.PASS, 0);
    check("rst_pcnt", ifa.PASS_CNT, 0);
    check("rst_cyc", ifa.CYCLE_CNT, 0);
    check("rst_ev", ifa.CHK_EVENT, 0);
    rst_n = 1'b1;
    step();

    wr(0, 4, 32'h0eec);
    wr(1, 6, 32'h0000);
    wr(2, 8, 32'h0001);

    // 1: all pass
    go(3);
    for (int n = 1; n <= 9; n++) begin
      num_inst = DW'(n); output_port = good_ans(n);
      step();
      check("t1_ev", ifa.CHK_EVENT, (n == 4 || n == 6 || n == 8) ? 1 : 0);
      if (n == 4 || n == 6 || n == 8) begin
        check("t1_ok", ifa.CHK_OK, 1);
        check("t1_idx", ifa.CHK_IDX, (n - 4) / 2);
      end
    end
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("t1_pcnt", ifa.PASS_CNT, 3);
    check("t1_done", ifa.DONE, 1);
    check("t1_pass", ifa.PASS, 1);
    check("t1_cyc", ifa.CYCLE_CNT, 10);
    check("t1_pass_b", ifb.PASS, 1);
    step();
    check("t1_hold_cyc", ifa.CYCLE_CNT, 10);
    check("t1_hold_done", ifa.DONE, 1);

    // 2: wrong value at first checkpoint, restart from DONE
    go(3);
    for (int n = 1; n <= 4; n++) begin
      num_inst = DW'(n); output_port = (n == 4) ? 32'h0eed : 32'h0;
      step();
    end
    check("t2_ev", ifa.CHK_EVENT, 1);
    check("t2_ok", ifa.CHK_OK, 0);
    check("t2_fcnt", ifa.FAIL_CNT, 1);
    check("t2_ffidx", ifa.FIRST_FAIL_IDX, 0);
    check("t2_ffval", ifa.FIRST_FAIL_VAL, 32'h0eed);
    check("t2_done", ifa.DONE, 1);
    check("t2_pass", ifa.PASS, 0);
    check("t2_b_run", ifb.DONE, 0);
    halt = 1'b1; step(); halt = 1'b0;

    // 3: jump past all entries
    go(3);
    num_inst = 2;
    step();
    check("t3_noev", ifb.CHK_EVENT, 0);
    num_inst = 10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_ev", ifb.CHK_EVENT, 1);
      check("t3_idx", ifb.CHK_IDX, i);
      check("t3_miss", ifb.CHK_MISS, 1);
      check("t3_ok", ifb.CHK_OK, 0);
      if (i == 0) begin
        check("t3_a_done", ifa.DONE, 1);
        check("t3_a_miss", ifa.CHK_MISS, 1);
      end
    end
    check("t3_fcnt", ifb.FAIL_CNT, 3);
    check("t3_ffidx", ifb.FIRST_FAIL_IDX, 0);
    check("t3_ffval", ifb.FIRST_FAIL_VAL, 0);
    check("t3_a_fcnt", ifa.FAIL_CNT, 1);
    step();
    check("t3_ev_end", ifb.CHK_EVENT, 0);
    halt = 1'b1; step(); halt = 1'b0;
    check("t3_b_pass", ifb.PASS, 0);
    check("t3_b_inc", ifb.INCOMPLETE, 0);

    // 4: HALT at the second checkpoint
    go(3);
    for (int n = 1; n <= 6; n++) begin
      num_inst = DW'(n); output_port = good_ans(n); halt = (n == 6);
      step();
    end
    halt = 1'b0;
    check("t4_ev", ifa.CHK_EVENT, 1);
    check("t4_pcnt", ifa.PASS_CNT, 2);
    check("t4_inc", ifa.INCOMPLETE, 1);
    check("t4_done", ifa.DONE, 1);
    check("t4_pass", ifa.PASS, 0);

    // 5: watchdog with no entries, NUM_INST frozen at 5
    num_entries = '0; num_inst = 5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("t5_to_15", ifa.TIMEOUT, 0);
    check("t5_done_15", ifa.DONE, 0);
    step();
    check("t5_to_16", ifa.TIMEOUT, 1);
    check("t5_done_16", ifa.DONE, 1);
    check("t5_pass", ifa.PASS, 0);
    check("t5_cyc", ifa.CYCLE_CNT, 16);
    check("t5_b_done", ifb.DONE, 0);
    check("t5_b_to", ifb.TIMEOUT, 0);
    halt = 1'b1; step(); halt = 1'b0;

    // 6: reset mid-RUN
    go(3);
    for (int n = 1; n <= 4; n++) begin
      num_inst = DW'(n); output_port = good_ans(n);
      step();
    end
    check("t6_pre_ev", ifa.CHK_EVENT, 1);
    rst_n = 1'b0;
    #1;
    check("t6_ev", ifa.CHK_EVENT, 0);
    check("t6_pcnt", ifa.PASS_CNT, 0);
    check("t6_cyc", ifa.CYCLE_CNT, 0);
    check("t6_ok", ifa.CHK_OK, 0);
    #1;
    rst_n = 1'b1;
    step();

    // 7: write and START together; entry 1 retained across reset
    cfg_we = 1'b1; cfg_addr = 0; cfg_inst = 4; cfg_ans = 32'h1234;
    num_entries = 2; num_inst = '0; output_port = '0; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      num_inst = DW'(n); output_port = (n == 4) ? 32'h1234 : 32'h0;
      step();
    end
    check("t7_pcnt", ifa.PASS_CNT, 2);
    check("t7_fcnt", ifa.FAIL_CNT, 0);
    halt = 1'b1; step(); halt = 1'b0;
    check("t7_pass", ifa.PASS, 1);
    check("t7_inc", ifa.INCOMPLETE, 0);

`ifdef CHK_MASK_EN
    // 8: masked compare
    rst_n = 1'b0; #1; rst_n = 1'b1;
    step();
    cfg_mask = 32'hff00;
    cfg_we = 1'b1; cfg_addr = 0; cfg_inst = 4; cfg_ans = 32'h0e00;
    num_entries = 1; num_inst = '0; output_port = '0; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0; cfg_mask = '1;
    for (int n = 1; n <= 4; n++) begin
      num_inst = DW'(n); output_port = (n == 4) ? 32'h0eec : 32'h0;
      step();
    end
    check("t8_ev", ifa.CHK_EVENT, 1);
    check("t8_ok", ifa.CHK_OK, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
